// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, captures CDB results, forwards operands, retires 1/cycle.
// Latency: CDB at edge t makes head committable at edge t+1; commit/flush outputs are registered (1 cycle).
// Backpressure: out_rob_full blocks allocation (even on a same-edge commit); rdy=0 freezes all state.
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable)
//   in_decoder_*            allocation request; out_decoder_tag = tag the next allocation receives
//   out_rob_full            15 live entries (tag 0 is reserved as "no tag")
//   in_cdb_*                result broadcast (value, branch outcome, branch target)
//   in_query_tag1/2         operand lookups -> out_query_ready1/2, out_query_value1/2 (combinational, CDB bypass)
//   out_commit_reg/tag/value regfile commit port; reg 0 means nothing retired this cycle
//   out_xbp / out_xbp_pc    one-cycle mispredict flush pulse and redirect PC
//   out_stat_commits/flushes statistics counters
//
// Optional feature: define ROB_STATS_EN to build the retirement/flush counters; otherwise they read 0.

module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_WIDTH = 4,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_decoder_valid,
  input  logic [REG_WIDTH-1:0] in_decoder_dest_reg,
  input  logic [31:0]          in_decoder_pc,
  input  logic                 in_decoder_is_branch,
  input  logic                 in_decoder_pred_taken,
  output logic [ROB_WIDTH-1:0] out_decoder_tag,
  output logic                 out_rob_full,
  input  logic                 in_cdb_valid,
  input  logic [ROB_WIDTH-1:0] in_cdb_tag,
  input  logic [31:0]          in_cdb_value,
  input  logic                 in_cdb_taken,
  input  logic [31:0]          in_cdb_jump_addr,
  input  logic [ROB_WIDTH-1:0] in_query_tag1,
  input  logic [ROB_WIDTH-1:0] in_query_tag2,
  output logic                 out_query_ready1,
  output logic [31:0]          out_query_value1,
  output logic                 out_query_ready2,
  output logic [31:0]          out_query_value2,
  output logic [REG_WIDTH-1:0] out_commit_reg,
  output logic [ROB_WIDTH-1:0] out_commit_tag,
  output logic [31:0]          out_commit_value,
  output logic                 out_xbp,
  output logic [31:0]          out_xbp_pc,
  output logic [31:0]          out_stat_commits,
  output logic [15:0]          out_stat_flushes
);

  localparam logic [ROB_WIDTH-1:0] FIRST_TAG = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH-1:0] LAST_TAG  = ROB_WIDTH'(ROB_SIZE - 1);

  // Tags cycle 1..ROB_SIZE-1 and skip 0, which means "no producer".
  function automatic logic [ROB_WIDTH-1:0] tag_inc(input logic [ROB_WIDTH-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  // Per-entry state
  logic [ROB_SIZE-1:0]                busy_q,  busy_d;
  logic [ROB_SIZE-1:0]                ready_q, ready_d;
  logic [ROB_SIZE-1:0]                is_br_q, is_br_d;
  logic [ROB_SIZE-1:0]                pred_q,  pred_d;
  logic [ROB_SIZE-1:0]                taken_q, taken_d;
  logic [ROB_SIZE-1:0][REG_WIDTH-1:0] dest_q,  dest_d;
  logic [ROB_SIZE-1:0][31:0]          pc_q,    pc_d;
  logic [ROB_SIZE-1:0][31:0]          value_q, value_d;
  logic [ROB_SIZE-1:0][31:0]          jump_q,  jump_d;

  // Queue pointers
  logic [ROB_WIDTH-1:0] head_q,  head_d;
  logic [ROB_WIDTH-1:0] tail_q,  tail_d;
  logic [ROB_WIDTH-1:0] count_q, count_d;

  // Registered outputs
  logic [REG_WIDTH-1:0] commit_reg_q,   commit_reg_d;
  logic [ROB_WIDTH-1:0] commit_tag_q,   commit_tag_d;
  logic [31:0]          commit_value_q, commit_value_d;
  logic                 xbp_q,          xbp_d;
  logic [31:0]          xbp_pc_q,       xbp_pc_d;

  logic full;
  logic alloc_en;
  logic cdb_en;
  logic commit_en;
  logic mispredict;

  assign full     = (count_q == LAST_TAG);
  assign alloc_en = rdy && in_decoder_valid && !full;
  assign cdb_en   = rdy && in_cdb_valid && (in_cdb_tag != '0) && busy_q[in_cdb_tag];
  // An empty ROB has busy_q[head_q]=0, so no separate empty test is needed.
  assign commit_en  = rdy && busy_q[head_q] && ready_q[head_q];
  assign mispredict = commit_en && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    is_br_d        = is_br_q;
    pred_d         = pred_q;
    taken_d        = taken_q;
    dest_d         = dest_q;
    pc_d           = pc_q;
    value_d        = value_q;
    jump_d         = jump_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_reg_d   = '0;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;
    xbp_d          = 1'b0;
    xbp_pc_d       = xbp_pc_q;

    if (cdb_en) begin
      ready_d[in_cdb_tag] = 1'b1;
      value_d[in_cdb_tag] = in_cdb_value;
      taken_d[in_cdb_tag] = in_cdb_taken;
      jump_d[in_cdb_tag]  = in_cdb_jump_addr;
    end

    // tail never equals a busy head while not full, so alloc and commit never touch the same entry.
    if (alloc_en) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      dest_d[tail_q]  = in_decoder_dest_reg;
      pc_d[tail_q]    = in_decoder_pc;
      is_br_d[tail_q] = in_decoder_is_branch;
      pred_d[tail_q]  = in_decoder_pred_taken;
      tail_d          = tag_inc(tail_q);
    end

    if (commit_en) begin
      // Branches never write back, whatever dest the decoder supplied.
      commit_reg_d    = is_br_q[head_q] ? '0 : dest_q[head_q];
      commit_tag_d    = head_q;
      commit_value_d  = value_q[head_q];
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = tag_inc(head_q);
    end

    unique case ({alloc_en, commit_en})
      2'b10:   count_d = count_q + FIRST_TAG;
      2'b01:   count_d = count_q - FIRST_TAG;
      default: count_d = count_q;
    endcase

    // A flush overrides every same-edge alloc and CDB capture above.
    if (mispredict) begin
      busy_d   = '0;
      ready_d  = '0;
      head_d   = FIRST_TAG;
      tail_d   = FIRST_TAG;
      count_d  = '0;
      xbp_d    = 1'b1;
      xbp_pc_d = taken_q[head_q] ? jump_q[head_q] : pc_q[head_q] + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q         <= '0;
      ready_q        <= '0;
      is_br_q        <= '0;
      pred_q         <= '0;
      taken_q        <= '0;
      dest_q         <= '0;
      pc_q           <= '0;
      value_q        <= '0;
      jump_q         <= '0;
      head_q         <= FIRST_TAG;
      tail_q         <= FIRST_TAG;
      count_q        <= '0;
      commit_reg_q   <= '0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      xbp_q          <= 1'b0;
      xbp_pc_q       <= '0;
    end else begin
      // With rdy low the next-state logic already reproduces current state,
      // except commit_reg/xbp which drop to 0 so no stale pulse repeats.
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      is_br_q        <= is_br_d;
      pred_q         <= pred_d;
      taken_q        <= taken_d;
      dest_q         <= dest_d;
      pc_q           <= pc_d;
      value_q        <= value_d;
      jump_q         <= jump_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_reg_q   <= commit_reg_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
      xbp_q          <= xbp_d;
      xbp_pc_q       <= xbp_pc_d;
    end
  end

  // Operand lookup: stored result first, else same-cycle CDB bypass; free/zero tags report not ready.
  always_comb begin
    out_query_ready1 = 1'b0;
    out_query_value1 = '0;
    if (in_query_tag1 != '0 && busy_q[in_query_tag1]) begin
      if (ready_q[in_query_tag1]) begin
        out_query_ready1 = 1'b1;
        out_query_value1 = value_q[in_query_tag1];
      end else if (in_cdb_valid && in_cdb_tag == in_query_tag1) begin
        out_query_ready1 = 1'b1;
        out_query_value1 = in_cdb_value;
      end
    end
  end

  always_comb begin
    out_query_ready2 = 1'b0;
    out_query_value2 = '0;
    if (in_query_tag2 != '0 && busy_q[in_query_tag2]) begin
      if (ready_q[in_query_tag2]) begin
        out_query_ready2 = 1'b1;
        out_query_value2 = value_q[in_query_tag2];
      end else if (in_cdb_valid && in_cdb_tag == in_query_tag2) begin
        out_query_ready2 = 1'b1;
        out_query_value2 = in_cdb_value;
      end
    end
  end

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits_q;
  logic [15:0] stat_flushes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_commits_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (commit_en)  stat_commits_q <= stat_commits_q + 32'd1;
      if (mispredict) stat_flushes_q <= stat_flushes_q + 16'd1;
    end
  end

  assign out_stat_commits = stat_commits_q;
  assign out_stat_flushes = stat_flushes_q;
`else
  assign out_stat_commits = '0;
  assign out_stat_flushes = '0;
`endif

  assign out_decoder_tag  = tail_q;
  assign out_rob_full     = full;
  assign out_commit_reg   = commit_reg_q;
  assign out_commit_tag   = commit_tag_q;
  assign out_commit_value = commit_value_q;
  assign out_xbp          = xbp_q;
  assign out_xbp_pc       = xbp_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_decoder_valid;
  logic [4:0]  in_decoder_dest_reg;
  logic [31:0] in_decoder_pc;
  logic        in_decoder_is_branch;
  logic        in_decoder_pred_taken;
  logic [3:0]  out_decoder_tag;
  logic        out_rob_full;
  logic        in_cdb_valid;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value;
  logic        in_cdb_taken;
  logic [31:0] in_cdb_jump_addr;
  logic [3:0]  in_query_tag1, in_query_tag2;
  logic        out_query_ready1, out_query_ready2;
  logic [31:0] out_query_value1, out_query_value2;
  logic [4:0]  out_commit_reg;
  logic [3:0]  out_commit_tag;
  logic [31:0] out_commit_value;
  logic        out_xbp;
  logic [31:0] out_xbp_pc;
  logic [31:0] out_stat_commits;
  logic [15:0] out_stat_flushes;

  int checks = 0;
  int passed = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_decoder_valid(in_decoder_valid), .in_decoder_dest_reg(in_decoder_dest_reg),
    .in_decoder_pc(in_decoder_pc), .in_decoder_is_branch(in_decoder_is_branch),
    .in_decoder_pred_taken(in_decoder_pred_taken),
    .out_decoder_tag(out_decoder_tag), .out_rob_full(out_rob_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_taken(in_cdb_taken), .in_cdb_jump_addr(in_cdb_jump_addr),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_ready1(out_query_ready1), .out_query_value1(out_query_value1),
    .out_query_ready2(out_query_ready2), .out_query_value2(out_query_value2),
    .out_commit_reg(out_commit_reg), .out_commit_tag(out_commit_tag),
    .out_commit_value(out_commit_value), .out_xbp(out_xbp), .out_xbp_pc(out_xbp_pc),
    .out_stat_commits(out_stat_commits), .out_stat_flushes(out_stat_flushes)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] dest, input logic [31:0] pc,
                       input logic br, input logic pred);
    in_decoder_valid      = 1'b1;
    in_decoder_dest_reg   = dest;
    in_decoder_pc         = pc;
    in_decoder_is_branch  = br;
    in_decoder_pred_taken = pred;
    step();
    in_decoder_valid      = 1'b0;
    in_decoder_is_branch  = 1'b0;
    in_decoder_pred_taken = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                     input logic tk, input logic [31:0] jmp);
    in_cdb_valid     = 1'b1;
    in_cdb_tag       = tag;
    in_cdb_value     = val;
    in_cdb_taken     = tk;
    in_cdb_jump_addr = jmp;
    step();
    in_cdb_valid     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1;
    in_decoder_valid = 0; in_decoder_dest_reg = 0; in_decoder_pc = 0;
    in_decoder_is_branch = 0; in_decoder_pred_taken = 0;
    in_cdb_valid = 0; in_cdb_tag = 0; in_cdb_value = 0; in_cdb_taken = 0; in_cdb_jump_addr = 0;
    in_query_tag1 = 0; in_query_tag2 = 0;
    #12;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL rst_tag got %0h exp 1", out_decoder_tag); else passed++;
    checks++; if (out_rob_full !== 1'b0) $display("FAIL rst_full got %0b exp 0", out_rob_full); else passed++;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL rst_creg got %0h exp 0", out_commit_reg); else passed++;
    checks++; if (out_commit_tag !== 4'd0) $display("FAIL rst_ctag got %0h exp 0", out_commit_tag); else passed++;
    checks++; if (out_commit_value !== 32'd0) $display("FAIL rst_cval got %0h exp 0", out_commit_value); else passed++;
    checks++; if (out_xbp !== 1'b0) $display("FAIL rst_xbp got %0b exp 0", out_xbp); else passed++;
    checks++; if (out_xbp_pc !== 32'd0) $display("FAIL rst_xbp_pc got %0h exp 0", out_xbp_pc); else passed++;
    checks++; if (out_stat_commits !== 32'd0) $display("FAIL rst_stat got %0h exp 0", out_stat_commits); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_alloc_commit();
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL ac_tag_before got %0h exp 1", out_decoder_tag); else passed++;
    alloc(5'd5, 32'h10, 1'b0, 1'b0);
    checks++; if (out_decoder_tag !== 4'd2) $display("FAIL ac_tag_after got %0h exp 2", out_decoder_tag); else passed++;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL ac_no_commit got %0h exp 0", out_commit_reg); else passed++;
    cdb(4'd1, 32'h1234, 1'b0, 32'h0);
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL ac_commit_early got %0h exp 0", out_commit_reg); else passed++;
    step();
    checks++; if (out_commit_reg !== 5'd5) $display("FAIL ac_creg got %0h exp 5", out_commit_reg); else passed++;
    checks++; if (out_commit_tag !== 4'd1) $display("FAIL ac_ctag got %0h exp 1", out_commit_tag); else passed++;
    checks++; if (out_commit_value !== 32'h1234) $display("FAIL ac_cval got %0h exp 1234", out_commit_value); else passed++;
    step();
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL ac_one_shot got %0h exp 0", out_commit_reg); else passed++;
`ifdef ROB_STATS_EN
    checks++; if (out_stat_commits !== 32'd1) $display("FAIL ac_stat got %0d exp 1", out_stat_commits); else passed++;
`else
    checks++; if (out_stat_commits !== 32'd0) $display("FAIL ac_stat got %0d exp 0", out_stat_commits); else passed++;
`endif
  endtask

  task automatic test_query_bypass();
    // head=tail=2 on entry
    alloc(5'd6, 32'h20, 1'b0, 1'b0);
    alloc(5'd7, 32'h24, 1'b0, 1'b0);
    checks++; if (out_decoder_tag !== 4'd4) $display("FAIL q_tag got %0h exp 4", out_decoder_tag); else passed++;
    in_query_tag1 = 4'd3; in_query_tag2 = 4'd2;
    in_cdb_valid = 1'b1; in_cdb_tag = 4'd3; in_cdb_value = 32'hABCD; in_cdb_taken = 0; in_cdb_jump_addr = 0;
    #1;
    checks++; if (out_query_ready1 !== 1'b1) $display("FAIL q_byp_rdy got %0b exp 1", out_query_ready1); else passed++;
    checks++; if (out_query_value1 !== 32'hABCD) $display("FAIL q_byp_val got %0h exp abcd", out_query_value1); else passed++;
    checks++; if (out_query_ready2 !== 1'b0) $display("FAIL q_pend_rdy got %0b exp 0", out_query_ready2); else passed++;
    checks++; if (out_query_value2 !== 32'd0) $display("FAIL q_pend_val got %0h exp 0", out_query_value2); else passed++;
    step();
    in_cdb_valid = 1'b0;
    #1;
    checks++; if (out_query_ready1 !== 1'b1) $display("FAIL q_stored_rdy got %0b exp 1", out_query_ready1); else passed++;
    checks++; if (out_query_value1 !== 32'hABCD) $display("FAIL q_stored_val got %0h exp abcd", out_query_value1); else passed++;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL q_inorder got %0h exp 0", out_commit_reg); else passed++;
    in_query_tag1 = 4'd0;
    #1;
    checks++; if (out_query_ready1 !== 1'b0) $display("FAIL q_tag0 got %0b exp 0", out_query_ready1); else passed++;
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    step();
    checks++; if (out_commit_reg !== 5'd6) $display("FAIL q_c1_reg got %0h exp 6", out_commit_reg); else passed++;
    checks++; if (out_commit_value !== 32'h22) $display("FAIL q_c1_val got %0h exp 22", out_commit_value); else passed++;
    step();
    checks++; if (out_commit_reg !== 5'd7) $display("FAIL q_c2_reg got %0h exp 7", out_commit_reg); else passed++;
    checks++; if (out_commit_tag !== 4'd3) $display("FAIL q_c2_tag got %0h exp 3", out_commit_tag); else passed++;
    checks++; if (out_commit_value !== 32'hABCD) $display("FAIL q_c2_val got %0h exp abcd", out_commit_value); else passed++;
    in_query_tag1 = 4'd3;
    #1;
    checks++; if (out_query_ready1 !== 1'b0) $display("FAIL q_freed got %0b exp 0", out_query_ready1); else passed++;
    in_query_tag1 = 4'd0; in_query_tag2 = 4'd0;
  endtask

  task automatic test_mispredict();
    // head=tail=4 on entry
    alloc(5'd0, 32'h100, 1'b1, 1'b0);
    alloc(5'd9, 32'h104, 1'b0, 1'b0);
    checks++; if (out_decoder_tag !== 4'd6) $display("FAIL mp_tag got %0h exp 6", out_decoder_tag); else passed++;
    cdb(4'd4, 32'h0, 1'b1, 32'h200);
    // alloc and CDB on the flush edge must both be discarded
    in_decoder_valid = 1'b1; in_decoder_dest_reg = 5'd3; in_decoder_pc = 32'h108;
    in_cdb_valid = 1'b1; in_cdb_tag = 4'd5; in_cdb_value = 32'h55; in_cdb_taken = 0;
    step();
    in_decoder_valid = 1'b0; in_cdb_valid = 1'b0;
    checks++; if (out_xbp !== 1'b1) $display("FAIL mp_xbp got %0b exp 1", out_xbp); else passed++;
    checks++; if (out_xbp_pc !== 32'h200) $display("FAIL mp_pc got %0h exp 200", out_xbp_pc); else passed++;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL mp_creg got %0h exp 0", out_commit_reg); else passed++;
    checks++; if (out_commit_tag !== 4'd4) $display("FAIL mp_ctag got %0h exp 4", out_commit_tag); else passed++;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL mp_tag_reset got %0h exp 1", out_decoder_tag); else passed++;
    checks++; if (out_rob_full !== 1'b0) $display("FAIL mp_full got %0b exp 0", out_rob_full); else passed++;
    step();
    checks++; if (out_xbp !== 1'b0) $display("FAIL mp_pulse got %0b exp 0", out_xbp); else passed++;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL mp_cleared got %0h exp 0", out_commit_reg); else passed++;
    // correctly predicted taken branch
    alloc(5'd0, 32'h300, 1'b1, 1'b1);
    cdb(4'd1, 32'h0, 1'b1, 32'h400);
    step();
    checks++; if (out_xbp !== 1'b0) $display("FAIL br_ok_xbp got %0b exp 0", out_xbp); else passed++;
    checks++; if (out_commit_tag !== 4'd1) $display("FAIL br_ok_ctag got %0h exp 1", out_commit_tag); else passed++;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL br_ok_creg got %0h exp 0", out_commit_reg); else passed++;
    checks++; if (out_decoder_tag !== 4'd2) $display("FAIL br_ok_tag got %0h exp 2", out_decoder_tag); else passed++;
    // predicted taken, actually not taken: redirect to pc+4
    alloc(5'd0, 32'h500, 1'b1, 1'b1);
    cdb(4'd2, 32'h0, 1'b0, 32'h999);
    step();
    checks++; if (out_xbp !== 1'b1) $display("FAIL mp_nt_xbp got %0b exp 1", out_xbp); else passed++;
    checks++; if (out_xbp_pc !== 32'h504) $display("FAIL mp_nt_pc got %0h exp 504", out_xbp_pc); else passed++;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL mp_nt_tag got %0h exp 1", out_decoder_tag); else passed++;
    step();
`ifdef ROB_STATS_EN
    checks++; if (out_stat_commits !== 32'd6) $display("FAIL st_commits got %0d exp 6", out_stat_commits); else passed++;
    checks++; if (out_stat_flushes !== 16'd2) $display("FAIL st_flushes got %0d exp 2", out_stat_flushes); else passed++;
`else
    checks++; if (out_stat_commits !== 32'd0) $display("FAIL st_commits got %0d exp 0", out_stat_commits); else passed++;
    checks++; if (out_stat_flushes !== 16'd0) $display("FAIL st_flushes got %0d exp 0", out_stat_flushes); else passed++;
`endif
  endtask

  task automatic test_full_wrap();
    // head=tail=1, empty on entry
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        checks++; if (out_rob_full !== 1'b0) $display("FAIL fw_not_full got %0b exp 0", out_rob_full); else passed++;
      end
      alloc(5'(i), 32'(i * 4), 1'b0, 1'b0);
    end
    checks++; if (out_rob_full !== 1'b1) $display("FAIL fw_full got %0b exp 1", out_rob_full); else passed++;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL fw_wrap got %0h exp 1", out_decoder_tag); else passed++;
    in_decoder_valid = 1'b1; in_decoder_dest_reg = 5'd31; in_decoder_pc = 32'hF0;
    step();
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL fw_16th got %0h exp 1", out_decoder_tag); else passed++;
    // alloc still requested through the commit edge: full must gate it
    in_cdb_valid = 1'b1; in_cdb_tag = 4'd1; in_cdb_value = 32'h111; in_cdb_taken = 0;
    step();
    in_cdb_valid = 1'b0;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL fw_early got %0h exp 0", out_commit_reg); else passed++;
    step();
    checks++; if (out_commit_reg !== 5'd1) $display("FAIL fw_creg got %0h exp 1", out_commit_reg); else passed++;
    checks++; if (out_commit_value !== 32'h111) $display("FAIL fw_cval got %0h exp 111", out_commit_value); else passed++;
    checks++; if (out_rob_full !== 1'b0) $display("FAIL fw_freed got %0b exp 0", out_rob_full); else passed++;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL fw_gated got %0h exp 1", out_decoder_tag); else passed++;
    step();
    in_decoder_valid = 1'b0;
    checks++; if (out_decoder_tag !== 4'd2) $display("FAIL fw_realloc got %0h exp 2", out_decoder_tag); else passed++;
    checks++; if (out_rob_full !== 1'b1) $display("FAIL fw_refull got %0b exp 1", out_rob_full); else passed++;
  endtask

  task automatic test_async_reset();
    // head=2, ROB full on entry
    cdb(4'd2, 32'h222, 1'b0, 32'h0);
    cdb(4'd3, 32'h333, 1'b0, 32'h0);
    checks++; if (out_commit_reg !== 5'd2) $display("FAIL ar_pre got %0h exp 2", out_commit_reg); else passed++;
    #3;
    rst = 1'b0;
    #1;
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL ar_creg got %0h exp 0", out_commit_reg); else passed++;
    checks++; if (out_commit_value !== 32'd0) $display("FAIL ar_cval got %0h exp 0", out_commit_value); else passed++;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL ar_tag got %0h exp 1", out_decoder_tag); else passed++;
    checks++; if (out_rob_full !== 1'b0) $display("FAIL ar_full got %0b exp 0", out_rob_full); else passed++;
    checks++; if (out_xbp_pc !== 32'd0) $display("FAIL ar_xbp_pc got %0h exp 0", out_xbp_pc); else passed++;
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL ar_no_commit got %0h exp 0", out_commit_reg); else passed++;
  endtask

  task automatic test_rdy_hold();
    rdy = 1'b0;
    in_decoder_valid = 1'b1; in_decoder_dest_reg = 5'd4;
    step();
    in_decoder_valid = 1'b0;
    rdy = 1'b1;
    checks++; if (out_decoder_tag !== 4'd1) $display("FAIL rh_alloc got %0h exp 1", out_decoder_tag); else passed++;
    alloc(5'd4, 32'h40, 1'b0, 1'b0);
    cdb(4'd1, 32'h44, 1'b0, 32'h0);
    rdy = 1'b0;
    step();
    checks++; if (out_commit_reg !== 5'd0) $display("FAIL rh_commit got %0h exp 0", out_commit_reg); else passed++;
    rdy = 1'b1;
    step();
    checks++; if (out_commit_reg !== 5'd4) $display("FAIL rh_resume got %0h exp 4", out_commit_reg); else passed++;
    checks++; if (out_commit_value !== 32'h44) $display("FAIL rh_val got %0h exp 44", out_commit_value); else passed++;
  endtask

  initial begin
    test_reset();
    test_alloc_commit();
    test_query_bypass();
    test_mispredict();
    test_full_wrap();
    test_async_reset();
    test_rdy_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
